mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Word-addressed scratchpad responder with fixed request-to-response
//            latency, a one-deep pending slot and sticky error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_WID = 14,    // word-index width, 2^ADDR_WID words
    parameter int DATA_WID = 32,    // data word width
    parameter int LATENCY  = 2      // request-to-response cycles, 1..15
) (
    input  logic                mod_clk,
    input  logic                reset,
    input  logic [63:0]         base,
    input  logic                read_enable,
    input  logic [63:0]         read_addr,
    input  logic [63:0]         read_size,
    input  logic                write_enable,
    input  logic [63:0]         write_addr,
    input  logic [63:0]         write_size,
    input  logic [DATA_WID-1:0] write_data,
    input  logic                finish_read,
    input  logic                finish_write,
    output logic [63:0]         read_ready,
    output logic [DATA_WID-1:0] read_data,
    output logic [63:0]         write_ready,
    output logic                busy,
    output logic                err,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SERVE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [3:0] C_LAT_FIRST   = 4'(LATENCY - 1);
    localparam logic [3:0] C_LAT_PROMOTE = 4'(LATENCY);

    logic [1:0]          state_q, state_d;
    logic [3:0]          cnt_q;          // cycles left in SERVE before RESP

    // request currently in service
    logic                cur_wr_q;
    logic [63:0]         cur_addr_q;
    logic [63:0]         cur_size_q;
    logic [DATA_WID-1:0] cur_data_q;

    // one-deep pending slot
    logic                pend_vld_q;
    logic                pend_wr_q;
    logic [63:0]         pend_addr_q;
    logic [63:0]         pend_size_q;
    logic [DATA_WID-1:0] pend_data_q;

    logic                read_ready_q;
    logic                write_ready_q;
    logic [DATA_WID-1:0] read_data_q;
    logic                err_q;
    logic [31:0]         rd_count_q;
    logic [31:0]         wr_count_q;

    logic [DATA_WID-1:0] mem [0:(1 << ADDR_WID) - 1];

    // request steering
    logic                in_idle, in_serve, in_resp;
    logic                any_en, both_en;
    logic                take_cur, second_to_pend, first_to_pend, drop, promote;
    logic                first_wr;
    logic [63:0]         first_addr, first_size;

    // address decode of the in-service request
    logic [63:0]         offset;
    logic [ADDR_WID-1:0] word_idx;
    logic                out_of_range, size_bad;

    // output strobes
    logic                resp_rd, resp_wr;

    // burst markers carry no function; low offset bits are don't-care
    logic                unused_inputs;
    assign unused_inputs = ^{finish_read, finish_write, offset[1:0]};

    assign offset       = cur_addr_q - base;
    assign word_idx     = offset[ADDR_WID+1:2];
    assign out_of_range = (cur_addr_q < base) || (offset[63:ADDR_WID+2] != '0);
    assign size_bad     = (cur_size_q != 64'd4);

    // Decide where an incoming request goes: into service, the pending slot, or dropped.
    // A free slot during RESP is filled and immediately promoted, so the new
    // request goes straight into service behind the one finishing now.
    always_comb begin
        in_idle        = (state_q == S_IDLE);
        in_serve       = (state_q == S_SERVE);
        in_resp        = (state_q == S_RESP);
        any_en         = read_enable | write_enable;
        both_en        = read_enable & write_enable;
        first_wr       = write_enable;
        first_addr     = write_enable ? write_addr : read_addr;
        first_size     = write_enable ? write_size : read_size;
        take_cur       = any_en  & (in_idle | (in_resp & ~pend_vld_q));
        second_to_pend = both_en & (in_idle | (in_resp & ~pend_vld_q));
        first_to_pend  = any_en  & in_serve & ~pend_vld_q;
        drop           = (both_en & in_serve & ~pend_vld_q) | (any_en & pend_vld_q);
        promote        = in_resp & pend_vld_q;
    end

    // State register.
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (take_cur) begin
                    state_d = (LATENCY == 1) ? S_RESP : S_SERVE;
                end
            end
            S_SERVE: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = (promote | take_cur) ? S_SERVE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state.
    always_comb begin
        resp_rd = in_resp & ~cur_wr_q;
        resp_wr = in_resp &  cur_wr_q;
        busy    = ~in_idle | pend_vld_q;
    end

    // Latency counter, in-service request and pending slot.
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            cur_wr_q    <= 1'b0;
            cur_addr_q  <= '0;
            cur_size_q  <= '0;
            cur_data_q  <= '0;
            pend_vld_q  <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_size_q <= '0;
            pend_data_q <= '0;
        end else begin
            if (in_idle && take_cur) begin
                cnt_q <= C_LAT_FIRST;
            end else if (in_serve) begin
                cnt_q <= cnt_q - 4'd1;
            end else if (in_resp && (promote || take_cur)) begin
                cnt_q <= C_LAT_PROMOTE;
            end

            if (promote) begin
                cur_wr_q   <= pend_wr_q;
                cur_addr_q <= pend_addr_q;
                cur_size_q <= pend_size_q;
                cur_data_q <= pend_data_q;
            end else if (take_cur) begin
                cur_wr_q   <= first_wr;
                cur_addr_q <= first_addr;
                cur_size_q <= first_size;
                cur_data_q <= write_data;
            end

            if (second_to_pend) begin
                pend_vld_q  <= 1'b1;
                pend_wr_q   <= 1'b0;
                pend_addr_q <= read_addr;
                pend_size_q <= read_size;
                pend_data_q <= write_data;
            end else if (first_to_pend) begin
                pend_vld_q  <= 1'b1;
                pend_wr_q   <= first_wr;
                pend_addr_q <= first_addr;
                pend_size_q <= first_size;
                pend_data_q <= write_data;
            end else if (promote) begin
                pend_vld_q  <= 1'b0;
            end
        end
    end

    // Response registers, sticky error and completion counters.
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            read_ready_q  <= 1'b0;
            write_ready_q <= 1'b0;
            read_data_q   <= '0;
            err_q         <= 1'b0;
            rd_count_q    <= '0;
            wr_count_q    <= '0;
        end else begin
            read_ready_q  <= resp_rd;
            write_ready_q <= resp_wr;
            if (resp_rd) begin
                read_data_q <= out_of_range ? '0 : mem[word_idx];
                rd_count_q  <= rd_count_q + 32'd1;
            end
            if (resp_wr) begin
                wr_count_q  <= wr_count_q + 32'd1;
            end
            if (drop || (in_resp && (out_of_range || size_bad))) begin
                err_q <= 1'b1;
            end
        end
    end

    // Scratchpad write port; contents survive reset.
    always_ff @(posedge mod_clk) begin
        if (resp_wr && !out_of_range) begin
            mem[word_idx] <= cur_data_q;
        end
    end

    assign read_ready  = {63'd0, read_ready_q};
    assign write_ready = {63'd0, write_ready_q};
    assign read_data   = read_data_q;
    assign err         = err_q;
    assign rd_count    = rd_count_q;
    assign wr_count    = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed scoreboard bench for mem_responder (LATENCY 2 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        mod_clk = 1'b0;
    logic        reset   = 1'b0;
    logic [63:0] base    = 64'h1000;
    logic        re0 = 1'b0, we0 = 1'b0, re1 = 1'b0, we1 = 1'b0;
    logic [63:0] read_addr = '0, read_size = 64'd4;
    logic [63:0] write_addr = '0, write_size = 64'd4;
    logic [31:0] write_data = '0;
    logic        finish_read = 1'b0, finish_write = 1'b0;

    logic [63:0] rr0, wrdy0, rr1, wrdy1;
    logic [31:0] rd0, rd1, rdc0, wrc0, rdc1, wrc1;
    logic        busy0, err0, busy1, err1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit          wr;
        logic [31:0] data;
        int          cyc;
        bit          err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    mem_responder #(.ADDR_WID(14), .DATA_WID(32), .LATENCY(2)) u_dut0 (
        .mod_clk(mod_clk), .reset(reset), .base(base),
        .read_enable(re0), .read_addr(read_addr), .read_size(read_size),
        .write_enable(we0), .write_addr(write_addr), .write_size(write_size),
        .write_data(write_data), .finish_read(finish_read), .finish_write(finish_write),
        .read_ready(rr0), .read_data(rd0), .write_ready(wrdy0), .busy(busy0),
        .err(err0), .rd_count(rdc0), .wr_count(wrc0)
    );

    mem_responder #(.ADDR_WID(14), .DATA_WID(32), .LATENCY(1)) u_dut1 (
        .mod_clk(mod_clk), .reset(reset), .base(base),
        .read_enable(re1), .read_addr(read_addr), .read_size(read_size),
        .write_enable(we1), .write_addr(write_addr), .write_size(write_size),
        .write_data(write_data), .finish_read(finish_read), .finish_write(finish_write),
        .read_ready(rr1), .read_data(rd1), .write_ready(wrdy1), .busy(busy1),
        .err(err1), .rd_count(rdc1), .wr_count(wrc1)
    );

    always #5 mod_clk = ~mod_clk;

    // cyc holds the number of rising edges seen so far
    always @(posedge mod_clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int inst, input bit wr, input logic [31:0] data,
                        input int c, input bit e);
        exp_t x;
        x.wr = wr; x.data = data; x.cyc = c; x.err = e;
        if (inst == 0) q0.push_back(x);
        else           q1.push_back(x);
    endtask

    // One-cycle request pulse; e returns the edge index that samples it.
    task automatic pulse(input int inst, input bit w, input logic [63:0] wa,
                         input logic [31:0] wd, input bit r, input logic [63:0] ra,
                         input logic [63:0] rs, output int e);
        @(negedge mod_clk);
        write_addr = wa; write_data = wd; write_size = 64'd4;
        read_addr  = ra; read_size  = rs;
        if (inst == 0) begin we0 = w; re0 = r; end
        else           begin we1 = w; re1 = r; end
        e = cyc + 1;
        @(posedge mod_clk);
        #1;
        we0 = 1'b0; re0 = 1'b0; we1 = 1'b0; re1 = 1'b0;
    endtask

    task automatic wait_idle(input int inst);
        int n = 0;
        do begin
            @(negedge mod_clk);
            n++;
        end while (((inst == 0) ? busy0 : busy1) && n < 60);
        if (n >= 60) chk("idle_timeout", 64'd1, 64'd0);
        repeat (2) @(negedge mod_clk);
    endtask

    task automatic do_reset();
        @(negedge mod_clk);
        reset = 1'b1;
        @(negedge mod_clk);
        chk("rst_read_ready", rr0, 64'd0);
        chk("rst_write_ready", wrdy0, 64'd0);
        chk("rst_read_data", {32'd0, rd0}, 64'd0);
        chk("rst_busy", {63'd0, busy0}, 64'd0);
        chk("rst_err", {63'd0, err0}, 64'd0);
        chk("rst_rd_count", {32'd0, rdc0}, 64'd0);
        chk("rst_wr_count", {32'd0, wrc0}, 64'd0);
        chk("rst1_err", {63'd0, err1}, 64'd0);
        chk("rst1_read_data", {32'd0, rd1}, 64'd0);
        reset = 1'b0;
    endtask

    // Scoreboard monitor for the LATENCY=2 instance.
    always @(negedge mod_clk) begin
        exp_t x;
        if (!reset && (rr0 != 64'd0 || wrdy0 != 64'd0)) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp0_unexpected: actual rr=%h wr=%h required=no response cyc=%0d",
                         rr0, wrdy0, cyc);
            end else begin
                x = q0.pop_front();
                chk("resp0_cycle", 64'(cyc), 64'(x.cyc));
                chk("resp0_read_ready", rr0, x.wr ? 64'd0 : 64'd1);
                chk("resp0_write_ready", wrdy0, x.wr ? 64'd1 : 64'd0);
                if (!x.wr) chk("resp0_data", {32'd0, rd0}, {32'd0, x.data});
                chk("resp0_err", {63'd0, err0}, {63'd0, x.err});
            end
        end
    end

    // Scoreboard monitor for the LATENCY=1 instance.
    always @(negedge mod_clk) begin
        exp_t x;
        if (!reset && (rr1 != 64'd0 || wrdy1 != 64'd0)) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp1_unexpected: actual rr=%h wr=%h required=no response cyc=%0d",
                         rr1, wrdy1, cyc);
            end else begin
                x = q1.pop_front();
                chk("resp1_cycle", 64'(cyc), 64'(x.cyc));
                chk("resp1_read_ready", rr1, x.wr ? 64'd0 : 64'd1);
                chk("resp1_write_ready", wrdy1, x.wr ? 64'd1 : 64'd0);
                if (!x.wr) chk("resp1_data", {32'd0, rd1}, {32'd0, x.data});
                chk("resp1_err", {63'd0, err1}, {63'd0, x.err});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e2;
        reset = 1'b1;
        repeat (2) @(negedge mod_clk);
        reset = 1'b0;
        do_reset();

        // write then read back, LATENCY 2
        finish_write = 1'b1;
        pulse(0, 1, 64'h1008, 32'hCAFE0001, 0, 64'h0, 64'd4, e);
        finish_write = 1'b0;
        push(0, 1, 32'h0, e + 2, 0);
        wait_idle(0);
        finish_read = 1'b1;
        pulse(0, 0, 64'h0, 32'h0, 1, 64'h1008, 64'd4, e);
        finish_read = 1'b0;
        push(0, 0, 32'hCAFE0001, e + 2, 0);
        wait_idle(0);
        chk("t1_wr_count", {32'd0, wrc0}, 64'd1);
        chk("t1_rd_count", {32'd0, rdc0}, 64'd1);
        chk("t1_data_hold", {32'd0, rd0}, 64'hCAFE0001);

        // enable in the idle cycle right after a response, no lost cycle
        pulse(0, 1, 64'h1004, 32'h12345678, 0, 64'h0, 64'd4, e);
        push(0, 1, 32'h0, e + 2, 0);
        repeat (2) @(posedge mod_clk);
        pulse(0, 0, 64'h0, 32'h0, 1, 64'h1004, 64'd4, e2);
        push(0, 0, 32'h12345678, e + 5, 0);
        wait_idle(0);

        // simultaneous write and read: write first, read three cycles later
        pulse(0, 1, 64'h1000, 32'h55, 1, 64'h1000, 64'd4, e);
        push(0, 1, 32'h0, e + 2, 0);
        push(0, 0, 32'h55, e + 5, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge mod_clk);
            chk("t2_busy_high", {63'd0, busy0}, 64'd1);
        end
        @(negedge mod_clk);
        chk("t2_busy_low", {63'd0, busy0}, 64'd0);
        wait_idle(0);

        // three back-to-back enables: third dropped
        pulse(0, 0, 64'h0, 32'h0, 1, 64'h1008, 64'd4, e);
        pulse(0, 1, 64'h100C, 32'hBEEF, 0, 64'h0, 64'd4, e2);
        pulse(0, 0, 64'h0, 32'h0, 1, 64'h1000, 64'd4, e2);
        push(0, 0, 32'hCAFE0001, e + 2, 1);
        push(0, 1, 32'h0, e + 5, 1);
        wait_idle(0);
        chk("t3_err", {63'd0, err0}, 64'd1);
        chk("t3_rd_count", {32'd0, rdc0}, 64'd4);
        chk("t3_wr_count", {32'd0, wrc0}, 64'd4);

        // out-of-range accesses
        do_reset();
        pulse(0, 0, 64'h0, 32'h0, 1, 64'h0FFC, 64'd4, e);
        push(0, 0, 32'h0, e + 2, 1);
        wait_idle(0);
        pulse(0, 0, 64'h0, 32'h0, 1, 64'h11000, 64'd4, e);
        push(0, 0, 32'h0, e + 2, 1);
        wait_idle(0);
        pulse(0, 1, 64'h11000, 32'hDEAD, 0, 64'h0, 64'd4, e);
        push(0, 1, 32'h0, e + 2, 1);
        wait_idle(0);
        pulse(0, 0, 64'h0, 32'h0, 1, 64'h1000, 64'd4, e);
        push(0, 0, 32'h55, e + 2, 1);
        wait_idle(0);
        chk("t4_rd_count", {32'd0, rdc0}, 64'd3);
        chk("t4_wr_count", {32'd0, wrc0}, 64'd1);

        // reset during SERVE of a write abandons it
        do_reset();
        pulse(0, 1, 64'h1010, 32'h11111111, 0, 64'h0, 64'd4, e);
        push(0, 1, 32'h0, e + 2, 0);
        wait_idle(0);
        do_reset();
        pulse(0, 1, 64'h1010, 32'h22222222, 0, 64'h0, 64'd4, e);
        #2;
        reset = 1'b1;
        @(negedge mod_clk);
        chk("t5_busy_in_reset", {63'd0, busy0}, 64'd0);
        reset = 1'b0;
        repeat (4) @(negedge mod_clk);
        chk("t5_wr_count", {32'd0, wrc0}, 64'd0);
        chk("t5_rd_count", {32'd0, rdc0}, 64'd0);
        pulse(0, 0, 64'h0, 32'h0, 1, 64'h1010, 64'd4, e);
        push(0, 0, 32'h11111111, e + 2, 0);
        wait_idle(0);

        // LATENCY 1 instance, including an illegal read size
        do_reset();
        pulse(1, 1, 64'h1008, 32'hA5A5A5A5, 0, 64'h0, 64'd4, e);
        push(1, 1, 32'h0, e + 1, 0);
        wait_idle(1);
        pulse(1, 0, 64'h0, 32'h0, 1, 64'h1008, 64'd8, e);
        push(1, 0, 32'hA5A5A5A5, e + 1, 1);
        wait_idle(1);
        chk("t6_rd_count", {32'd0, rdc1}, 64'd1);
        chk("t6_wr_count", {32'd0, wrc1}, 64'd1);

        repeat (4) @(negedge mod_clk);
        chk("sb0_empty", 64'(q0.size()), 64'd0);
        chk("sb1_empty", 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
